// File: rtl/vector_processor_top.sv
// Small vector processor: ROM-driven sequencer plus a memory access unit that
// streams 64 vector elements through an MCN handshake into an 8-bank memory.
module vector_processor_top (
   input  logic        clk,
   input  logic        reset,
   output logic [3:0]  pcout,
   output logic        pcinc,
   output logic [11:0] insout,
   output logic        ready,
   output logic        halt,
   output logic        stride_enable,
   output logic        mask_enable,
   output logic        rw,
   output logic [2:0]  vx_select,
   output logic [2:0]  rx_select,
   output logic [2:0]  ry_select,
   output logic [31:0] rxout,
   output logic [31:0] ryout,
   output logic [5:0]  vx_index,
   output logic [5:0]  mask_index,
   output logic        mask_bit,
   output logic [31:0] vxout,
   output logic        startMAU,
   output logic        doneMAU,
   output logic        ackMAU,
   output logic        reqMCN,
   output logic        ackMCN,
   output logic        rwMCN,
   output logic [8:0]  addrMCN,
   output logic [31:0] doutMCN,
   output logic        reqMEM,
   output logic        ackMEM,
   output logic        rwMEM,
   output logic [2:0]  bankSelect,
   output logic [5:0]  addrMEM,
   output logic [31:0] doutMEM,
   output logic [31:0] doutMAU
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_NEXT, S_HLT} seq_t;
   typedef enum logic [2:0] {M_IDLE, M_ISSUE, M_MEM, M_ACK, M_WB, M_SKIP} mau_t;

   localparam logic [63:0] MASK_RESET = 64'hAAAA_AAAA_AAAA_AAAA;

   seq_t r_seq, w_seq_nxt;
   mau_t r_mau, w_mau_nxt;

   logic [3:0]               r_pc;
   logic [11:0]              r_ins;
   logic [5:0]               r_idx;
   logic [31:0]              r_data;
   logic [7:0][31:0]         r_sreg;
   logic [63:0]              r_mask;
   logic [511:0][31:0]       r_mem;
   logic [7:0][63:0][31:0]   r_vreg;

   logic [2:0]  w_op;
   logic        w_ready, w_start, w_pcinc, w_done;
   logic        w_req_mcn, w_req_mem, w_ack, w_ack_mau;
   logic [5:0]  w_nidx;
   logic        w_nskip;
   logic [31:0] w_stride;
   logic [8:0]  w_addr;
   logic [31:0] w_memrd;
   logic        w_busy;

   function automatic logic [11:0] f_rom(input logic [3:0] a);
      case (a)
         4'd0:    f_rom = 12'h240;
         4'd1:    f_rom = 12'h68A;
         4'd2:    f_rom = 12'hAC0;
         4'd3:    f_rom = 12'h498;
         4'd4:    f_rom = 12'hE00;
         default: f_rom = 12'h000;
      endcase
   endfunction

   // Instruction decode
   assign w_op          = r_ins[11:9];
   assign vx_select     = r_ins[8:6];
   assign rx_select     = r_ins[5:3];
   assign ry_select     = r_ins[2:0];
   assign stride_enable = (w_op == 3'b011) || (w_op == 3'b100);
   assign mask_enable   = (w_op == 3'b101) || (w_op == 3'b110);
   assign rw            = (w_op == 3'b001) || (w_op == 3'b011) || (w_op == 3'b101);

   assign rxout      = r_sreg[rx_select];
   assign ryout      = r_sreg[ry_select];
   assign vx_index   = r_idx;
   assign mask_index = r_idx;
   assign mask_bit   = r_mask[r_idx];
   assign vxout      = r_vreg[vx_select][r_idx];

   // Element address; only the low 9 bits of base + i*stride matter (mod 512)
   assign w_stride   = stride_enable ? ryout : 32'd1;
   assign w_addr     = 9'(rxout + {26'd0, r_idx} * w_stride);
   assign addrMCN    = w_addr;
   assign bankSelect = w_addr[8:6];
   assign addrMEM    = w_addr[5:0];
   assign w_memrd    = r_mem[w_addr];

   // Sequencer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_seq <= S_FETCH;
      else        r_seq <= w_seq_nxt;
   end

   always_comb begin
      w_seq_nxt = r_seq;
      w_ready   = 1'b0;
      w_start   = 1'b0;
      w_pcinc   = 1'b0;
      case (r_seq)
         S_FETCH: begin
            w_ready   = 1'b1;
            w_seq_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (w_op == 3'b000)      w_seq_nxt = S_NEXT;
            else if (w_op == 3'b111) w_seq_nxt = S_HLT;
            else begin
               w_start   = 1'b1;
               w_seq_nxt = S_EXEC;
            end
         end
         S_EXEC:  if (w_done) w_seq_nxt = S_NEXT;
         S_NEXT: begin
            w_pcinc   = 1'b1;
            w_seq_nxt = S_FETCH;
         end
         S_HLT:   w_seq_nxt = S_HLT;
         default: w_seq_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc  <= 4'd0;
         r_ins <= f_rom(4'd0);
      end else begin
         if (r_seq == S_FETCH) r_ins <= f_rom(r_pc);
         if (r_seq == S_NEXT)  r_pc  <= r_pc + 4'd1;
      end
   end

   assign pcout    = r_pc;
   assign insout   = r_ins;
   assign ready    = w_ready;
   assign pcinc    = w_pcinc;
   assign startMAU = w_start;
   assign halt     = (r_seq == S_HLT);

   // MAU element sequencer; the next element's mask bit picks ISSUE or SKIP
   assign w_nidx  = (r_mau == M_IDLE) ? 6'd0 : r_idx + 6'd1;
   assign w_nskip = mask_enable && !r_mask[w_nidx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_mau <= M_IDLE;
      else        r_mau <= w_mau_nxt;
   end

   always_comb begin
      w_mau_nxt = r_mau;
      w_done    = 1'b0;
      w_req_mcn = 1'b0;
      w_req_mem = 1'b0;
      w_ack     = 1'b0;
      w_ack_mau = 1'b0;
      case (r_mau)
         M_IDLE:  if (w_start) w_mau_nxt = w_nskip ? M_SKIP : M_ISSUE;
         M_ISSUE: begin
            w_req_mcn = 1'b1;
            w_mau_nxt = M_MEM;
         end
         M_MEM: begin
            w_req_mem = 1'b1;
            w_mau_nxt = M_ACK;
         end
         M_ACK: begin
            w_ack     = 1'b1;
            w_mau_nxt = M_WB;
         end
         M_WB, M_SKIP: begin
            w_ack_mau = (r_mau == M_WB);
            if (r_idx == 6'd63) begin
               w_done    = 1'b1;
               w_mau_nxt = M_IDLE;
            end else begin
               w_mau_nxt = w_nskip ? M_SKIP : M_ISSUE;
            end
         end
         default: w_mau_nxt = M_IDLE;
      endcase
   end

   assign w_busy  = (r_mau != M_IDLE);
   assign doneMAU = w_done;
   assign reqMCN  = w_req_mcn;
   assign reqMEM  = w_req_mem;
   assign ackMCN  = w_ack;
   assign ackMEM  = w_ack;
   assign ackMAU  = w_ack_mau;
   assign rwMCN   = w_busy & rw;
   assign rwMEM   = w_busy & rw;
   assign doutMCN = (w_ack && rw) ? w_memrd : 32'd0;
   assign doutMEM = rw ? w_memrd : vxout;
   assign doutMAU = r_data;

   // Architectural state: element index, data latch, registers and memory
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx  <= 6'd0;
         r_data <= 32'd0;
         r_mask <= MASK_RESET;
         r_vreg <= '0;
         for (int k = 0; k < 8; k++)   r_sreg[k] <= 32'(k);
         for (int a = 0; a < 512; a++) r_mem[a]  <= 32'(a);
      end else begin
         if (r_mau == M_WB || r_mau == M_SKIP) r_idx <= r_idx + 6'd1;
         if (r_mau == M_ACK) begin
            r_data <= rw ? w_memrd : vxout;
            if (!rw) r_mem[w_addr] <= vxout;
         end
         if (r_mau == M_WB && rw) r_vreg[vx_select][r_idx] <= r_data;
      end
   end

endmodule

// File: tb/tb_vector_processor_top.sv
// Directed bench for vector_processor_top: runs the ROM program, checks every
// handshake, address and data beat, final register/memory contents, and reset.
module tb_vector_processor_top;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pcout;
   logic        pcinc;
   logic [11:0] insout;
   logic        ready, halt, stride_enable, mask_enable, rw;
   logic [2:0]  vx_select, rx_select, ry_select;
   logic [31:0] rxout, ryout;
   logic [5:0]  vx_index, mask_index;
   logic        mask_bit;
   logic [31:0] vxout;
   logic        startMAU, doneMAU, ackMAU, reqMCN, ackMCN, rwMCN;
   logic [8:0]  addrMCN;
   logic [31:0] doutMCN;
   logic        reqMEM, ackMEM, rwMEM;
   logic [2:0]  bankSelect;
   logic [5:0]  addrMEM;
   logic [31:0] doutMEM, doutMAU;

   vector_processor_top dut (
      .clk(clk), .reset(reset), .pcout(pcout), .pcinc(pcinc), .insout(insout),
      .ready(ready), .halt(halt), .stride_enable(stride_enable),
      .mask_enable(mask_enable), .rw(rw), .vx_select(vx_select),
      .rx_select(rx_select), .ry_select(ry_select), .rxout(rxout), .ryout(ryout),
      .vx_index(vx_index), .mask_index(mask_index), .mask_bit(mask_bit),
      .vxout(vxout), .startMAU(startMAU), .doneMAU(doneMAU), .ackMAU(ackMAU),
      .reqMCN(reqMCN), .ackMCN(ackMCN), .rwMCN(rwMCN), .addrMCN(addrMCN),
      .doutMCN(doutMCN), .reqMEM(reqMEM), .ackMEM(ackMEM), .rwMEM(rwMEM),
      .bankSelect(bankSelect), .addrMEM(addrMEM), .doutMEM(doutMEM),
      .doutMAU(doutMAU)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // Program table: instruction word, base address, stride, latency, requests, load?, masked?
   logic [11:0] ins_t  [4] = '{12'h240, 12'h68A, 12'hAC0, 12'h498};
   int          base_t [4] = '{0, 1, 0, 3};
   int          strd_t [4] = '{1, 2, 1, 1};
   int          lat_t  [4] = '{256, 256, 160, 256};
   int          nreq_t [4] = '{64, 64, 32, 64};
   bit          ld_t   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
   bit          msk_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int k, kk, cnt, start_cyc, cyc, eidx, npcinc;
      logic [8:0] ea;
      logic p_req, p_reqmem, p_ack;
      int expv;

      k = -1; kk = 0; cnt = 0; start_cyc = 0; cyc = 0; eidx = 0; npcinc = 0;
      ea = '0; p_req = 0; p_reqmem = 0; p_ack = 0;

      reset = 1'b0;
      #21 reset = 1'b1;
      #1;
      chk("rst_pc", 32'(pcout), 0);
      chk("rst_ins", 32'(insout), 32'h240);
      chk("rst_halt", 32'(halt), 0);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_hs", 32'({startMAU, doneMAU, ackMAU, reqMCN, ackMCN, reqMEM, ackMEM, pcinc}), 0);
      chk("rst_idx", 32'(vx_index), 0);

      for (int c = 0; c < 3000 && !halt; c++) begin
         @(negedge clk);
         cyc++;
         if (startMAU) begin
            k++;
            kk = (k > 3) ? 3 : k;
            chk("start_ins", 32'(insout), 32'(ins_t[kk]));
            start_cyc = cyc;
            cnt = 0;
         end
         if (reqMCN) begin
            eidx = msk_t[kk] ? 2 * cnt + 1 : cnt;
            ea   = 9'(base_t[kk] + eidx * strd_t[kk]);
            chk("req_idx", 32'(vx_index), 32'(eidx));
            chk("req_addr", 32'(addrMCN), 32'(ea));
            chk("req_rw", 32'(rwMCN), 32'(ld_t[kk]));
            cnt++;
         end
         if (reqMEM) begin
            chk("mem_after_req", 32'(p_req), 1);
            chk("bank", 32'(bankSelect), 32'(ea[8:6]));
            chk("addrMEM", 32'(addrMEM), 32'(ea[5:0]));
            chk("rwMEM", 32'(rwMEM), 32'(ld_t[kk]));
            if (ea == 9'd65) chk("bank_at_65", 32'(bankSelect), 1);
         end
         if (ackMCN) begin
            chk("ack_pair", 32'(ackMEM), 1);
            chk("ack_after_mem", 32'(p_reqmem), 1);
            if (ld_t[kk]) chk("load_data", doutMCN, 32'(ea));
            else          chk("store_data", doutMEM, 32'(1 + 2 * eidx));
         end
         if (ackMAU) begin
            chk("ackmau_after_ack", 32'(p_ack), 1);
            if (ld_t[kk]) chk("mau_data", doutMAU, 32'(ea));
         end
         if (doneMAU) begin
            chk("latency", 32'(cyc - start_cyc), 32'(lat_t[kk]));
            chk("req_count", 32'(cnt), 32'(nreq_t[kk]));
         end
         if (pcinc) npcinc++;
         p_req = reqMCN; p_reqmem = reqMEM; p_ack = ackMCN;
      end

      chk("halted", 32'(halt), 1);
      chk("starts", 32'(k), 3);
      chk("pcinc_count", 32'(npcinc), 4);
      chk("pc_at_halt", 32'(pcout), 4);
      repeat (20) @(negedge clk);
      chk("halt_sticky", 32'(halt), 1);
      chk("pc_frozen", 32'(pcout), 4);
      chk("idle_after_halt", 32'({reqMCN, startMAU, pcinc, ready}), 0);

      for (int i = 0; i < 64; i++) begin
         chk("V1", dut.r_vreg[1][i], 32'(i));
         chk("V2", dut.r_vreg[2][i], 32'(1 + 2 * i));
         chk("V3", dut.r_vreg[3][i], (i % 2 == 1) ? 32'(i) : 32'd0);
      end
      for (int a = 0; a < 512; a++) begin
         expv = (a >= 3 && a <= 66) ? 1 + 2 * (a - 3) : a;
         chk("mem", dut.r_mem[a], 32'(expv));
      end

      // Reset after halt restarts the program with fresh state
      #2 reset = 1'b0;
      #1;
      chk("rst2_pc", 32'(pcout), 0);
      chk("rst2_halt", 32'(halt), 0);
      chk("rst2_ins", 32'(insout), 32'h240);
      chk("rst2_mem3", dut.r_mem[3], 3);
      chk("rst2_v2", dut.r_vreg[2][5], 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      chk("rerun_v1", dut.r_vreg[1][1], 1);
      chk("rerun_busy", 32'(rwMCN), 1);

      // Reset mid-instruction aborts and reinitialises partial results
      #2 reset = 1'b0;
      #1;
      chk("abort_v1", dut.r_vreg[1][1], 0);
      chk("abort_pc", 32'(pcout), 0);
      chk("abort_idx", 32'(vx_index), 0);
      chk("abort_hs", 32'({reqMCN, reqMEM, ackMCN, ackMAU, rwMCN, rwMEM}), 0);
      #5 reset = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
